// File: rtl/cam_capture_rgb332_if.sv
// Purpose: camera-bus and frame-buffer write-port bundle for cam_capture_rgb332.
// Signals:
//   Href, Vsync, Datos[7:0]     camera parallel bus (driven by the sensor side)
//   addr[AW-1:0], data[DW-1:0]  frame-buffer write address / RGB332 pixel
//   regwrite                    one-cycle write strobe per stored pixel
//   frame_done                  one-cycle end-of-frame pulse
// Modports: master = capture block, slave = sensor/buffer side.
interface cam_capture_rgb332_if #(
  parameter int unsigned AW = 15,
  parameter int unsigned DW = 8
);
  logic          Href;
  logic          Vsync;
  logic [7:0]    Datos;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          regwrite;
  logic          frame_done;

  modport master (
    input  Href, Vsync, Datos,
    output addr, data, regwrite, frame_done
  );

  modport slave (
    output Href, Vsync, Datos,
    input  addr, data, regwrite, frame_done
  );
endinterface

// File: rtl/cam_capture_rgb332.sv
// Purpose: OV7670 capture stage. Samples Vsync/Href/Datos on PCLK, packs
// RGB565 byte pairs into RGB332 pixels and writes them to a linear frame
// buffer (addr = row*CAM_SCREEN_X + col), clipping to the stored window.
// Ports:
//   clk   camera PCLK, rising-edge sampling
//   rst   asynchronous active-low reset
//   bus   cam_capture_rgb332_if.master (camera bus in, buffer write port out)
module cam_capture_rgb332 #(
  parameter int unsigned AW           = 15,
  parameter int unsigned DW           = 8,
  parameter int unsigned CAM_SCREEN_X = 160,
  parameter int unsigned CAM_SCREEN_Y = 120
) (
  input  logic                  clk,
  input  logic                  rst,
  cam_capture_rgb332_if.master  bus
);

  localparam int unsigned CW = $clog2(CAM_SCREEN_X + 1);
  localparam int unsigned RW = $clog2(CAM_SCREEN_Y + 1);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [2:0] {
    WAIT_VS,
    VS_HIGH,
    LINE_WAIT,
    BYTE1,
    BYTE0
  } state_t;

  state_t        r_state,      w_state_nxt;
  logic [CW-1:0] r_col,        w_col_nxt;
  logic [RW-1:0] r_row,        w_row_nxt;
  logic [AW-1:0] r_wr_ptr,     w_wr_ptr_nxt;
  logic [LW-1:0] r_line_next,  w_line_next_nxt;
  logic [5:0]    r_pix_hi,     w_pix_hi_nxt;
  logic          r_wrote,      w_wrote_nxt;
  logic [AW-1:0] r_addr,       w_addr_nxt;
  logic [DW-1:0] r_data,       w_data_nxt;
  logic          r_regwrite,   w_regwrite_nxt;
  logic          r_frame_done, w_frame_done_nxt;
  logic          w_eol;
  logic          w_in_win;
  logic [DW-1:0] w_pixel;

  // byte0 keeps R4..R2 and G5..G3; byte1 contributes B4..B3
  assign w_pixel  = DW'({r_pix_hi, bus.Datos[4:3]});
  assign w_in_win = (r_col < CW'(CAM_SCREEN_X)) && (r_row < RW'(CAM_SCREEN_Y));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= WAIT_VS;
      r_col        <= '0;
      r_row        <= '0;
      r_wr_ptr     <= '0;
      r_line_next  <= '0;
      r_pix_hi     <= '0;
      r_wrote      <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_regwrite   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_col        <= w_col_nxt;
      r_row        <= w_row_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_line_next  <= w_line_next_nxt;
      r_pix_hi     <= w_pix_hi_nxt;
      r_wrote      <= w_wrote_nxt;
      r_addr       <= w_addr_nxt;
      r_data       <= w_data_nxt;
      r_regwrite   <= w_regwrite_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  // Next-state, write and end-of-line logic
  always_comb begin
    w_state_nxt      = r_state;
    w_col_nxt        = r_col;
    w_row_nxt        = r_row;
    w_wr_ptr_nxt     = r_wr_ptr;
    w_line_next_nxt  = r_line_next;
    w_pix_hi_nxt     = r_pix_hi;
    w_wrote_nxt      = r_wrote;
    w_addr_nxt       = r_addr;
    w_data_nxt       = r_data;
    w_regwrite_nxt   = 1'b0;
    w_frame_done_nxt = 1'b0;
    w_eol            = 1'b0;

    case (r_state)
      WAIT_VS: begin
        if (bus.Vsync) w_state_nxt = VS_HIGH;
      end

      VS_HIGH: begin
        if (!bus.Vsync) begin
          w_state_nxt     = LINE_WAIT;
          w_col_nxt       = '0;
          w_row_nxt       = '0;
          w_wr_ptr_nxt    = '0;
          w_line_next_nxt = LW'(CAM_SCREEN_X);
          w_wrote_nxt     = 1'b0;
        end
      end

      LINE_WAIT: begin
        if (bus.Vsync) begin
          w_state_nxt      = VS_HIGH;
          w_frame_done_nxt = r_wrote;
        end else if (bus.Href) begin
          w_pix_hi_nxt = {bus.Datos[7:5], bus.Datos[2:0]};
          w_state_nxt  = BYTE1;
        end
      end

      BYTE1: begin
        if (bus.Vsync) begin
          w_state_nxt      = VS_HIGH;
          w_frame_done_nxt = r_wrote;
        end else if (bus.Href) begin
          w_state_nxt = BYTE0;
          if (w_in_win) begin
            w_regwrite_nxt = 1'b1;
            w_addr_nxt     = r_wr_ptr;
            w_data_nxt     = w_pixel;
            w_wr_ptr_nxt   = r_wr_ptr + AW'(1);
            w_wrote_nxt    = 1'b1;
          end
          if (r_col < CW'(CAM_SCREEN_X)) w_col_nxt = r_col + CW'(1);
        end else begin
          // odd-length line: the held byte 0 is dropped
          w_eol       = 1'b1;
          w_state_nxt = LINE_WAIT;
        end
      end

      BYTE0: begin
        if (bus.Vsync) begin
          w_state_nxt      = VS_HIGH;
          w_frame_done_nxt = r_wrote;
        end else if (bus.Href) begin
          w_pix_hi_nxt = {bus.Datos[7:5], bus.Datos[2:0]};
          w_state_nxt  = BYTE1;
        end else begin
          w_eol       = 1'b1;
          w_state_nxt = LINE_WAIT;
        end
      end

      default: w_state_nxt = WAIT_VS;
    endcase

    // Running line base replaces row*CAM_SCREEN_X; rows past the window freeze it
    if (w_eol) begin
      w_col_nxt = '0;
      if (r_row < RW'(CAM_SCREEN_Y)) begin
        w_row_nxt       = r_row + RW'(1);
        w_wr_ptr_nxt    = AW'(r_line_next);
        w_line_next_nxt = r_line_next + LW'(CAM_SCREEN_X);
      end
    end
  end

  assign bus.addr       = r_addr;
  assign bus.data       = r_data;
  assign bus.regwrite   = r_regwrite;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_cam_capture_rgb332.sv
module tb_cam_capture_rgb332;
  localparam int unsigned AW = 15;
  localparam int unsigned DW = 8;
  localparam int unsigned SX = 160;
  localparam int unsigned SY = 120;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cam_capture_rgb332_if #(.AW(AW), .DW(DW)) bus ();

  cam_capture_rgb332 #(
    .AW(AW), .DW(DW), .CAM_SCREEN_X(SX), .CAM_SCREEN_Y(SY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // scoreboard and counters
  wr_t exp_q[$];
  int  wr_log[$];
  int  total = 0;
  int  bad = 0;
  int  n_wr = 0;
  int  last_addr = -1;
  int  last_data = -1;
  int  max_addr = 0;
  int  act_fd = 0;
  int  exp_fd = 0;
  bit  prev_we = 1'b0;

  // reference model state
  bit armed = 1'b0;
  bit in_frame = 1'b0;
  bit wrote = 1'b0;
  int line_idx = 0;

  // RGB565 -> RGB332: keep the top bits of each colour channel
  function automatic logic [7:0] rgb332(input logic [7:0] b0, input logic [7:0] b1);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = b0[7:3];
    g6 = {b0[2:0], b1[7:5]};
    b5 = b1[4:0];
    return {r5[4:2], g6[5:3], b5[4:3]};
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // monitor: pops one expectation per observed write
  always @(posedge clk) begin
    #1;
    if (bus.regwrite === 1'b1) begin
      wr_t e;
      n_wr++;
      last_addr = int'(bus.addr);
      last_data = int'(bus.data);
      wr_log.push_back(int'(bus.addr));
      if (int'(bus.addr) > max_addr) max_addr = int'(bus.addr);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr=%0d data=%h expected no write", bus.addr, bus.data);
      end else begin
        e = exp_q.pop_front();
        if (bus.addr !== e.a || bus.data !== e.d) begin
          bad++;
          $display("FAIL write: addr=%0d data=%h expected addr=%0d data=%h",
                   bus.addr, bus.data, e.a, e.d);
        end
      end
      total++;
      if (prev_we) begin
        bad++;
        $display("FAIL back_to_back: regwrite=1 on consecutive cycles, expected gap");
      end
    end
    if (bus.frame_done === 1'b1) act_fd++;
    prev_we = (bus.regwrite === 1'b1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_addr"}, int'(bus.addr), 0);
    check({name, "_data"}, int'(bus.data), 0);
    check({name, "_regwrite"}, int'(bus.regwrite), 0);
    check({name, "_frame_done"}, int'(bus.frame_done), 0);
  endtask

  task automatic vs_rise();
    @(negedge clk);
    bus.Vsync = 1'b1;
    bus.Href  = 1'b0;
    if (in_frame && wrote) exp_fd++;
    in_frame = 1'b0;
    armed    = 1'b1;
    idle(3);
  endtask

  task automatic vs_fall();
    @(negedge clk);
    bus.Vsync = 1'b0;
    if (armed) begin
      in_frame = 1'b1;
      wrote    = 1'b0;
      line_idx = 0;
    end
    idle(2);
  endtask

  function automatic void rand_bytes(input int n, output logic [7:0] q[$]);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endfunction

  // one line of camera bytes; keep_href leaves Href high (for aborts)
  task automatic drive_line(input logic [7:0] q[$], input bit keep_href, input int gap);
    if (in_frame) begin
      for (int c = 0; c < q.size() / 2; c++) begin
        if (line_idx < int'(SY) && c < int'(SX)) begin
          exp_q.push_back('{a: AW'(line_idx * int'(SX) + c), d: rgb332(q[2*c], q[2*c+1])});
          wrote = 1'b1;
        end
      end
    end
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      bus.Href  = 1'b1;
      bus.Datos = q[i];
    end
    if (!keep_href) begin
      @(negedge clk);
      bus.Href  = 1'b0;
      bus.Datos = 8'($urandom);
      idle(gap - 1);
      if (in_frame) line_idx++;
    end
  endtask

  task automatic start_test();
    wr_log.delete();
    max_addr = 0;
  endtask

  initial begin
    logic [7:0] q[$];
    int fd0;

    bus.Vsync = 1'b0;
    bus.Href  = 1'b0;
    bus.Datos = 8'h00;
    rst = 1'b0;
    idle(3);
    check_outputs_zero("in_reset");

    // partial frame before any Vsync must be ignored
    @(negedge clk) rst = 1'b1;
    start_test();
    for (int l = 0; l < 3; l++) begin
      rand_bytes(40, q);
      drive_line(q, 1'b0, 4);
    end
    idle(4);
    check("skip_partial_writes", wr_log.size(), 0);

    // single pixel conversion
    vs_rise();
    vs_fall();
    start_test();
    q.delete();
    q.push_back(8'hF8);
    q.push_back(8'h1F);
    drive_line(q, 1'b0, 4);
    check("single_count", wr_log.size(), 1);
    check("single_addr", last_addr, 0);
    check("single_data", last_data, 8'hE3);
    fd0 = act_fd;
    vs_rise();
    check("single_frame_done", act_fd - fd0, 1);

    // full frame
    vs_fall();
    start_test();
    for (int l = 0; l < int'(SY); l++) begin
      rand_bytes(2 * int'(SX), q);
      drive_line(q, 1'b0, 4);
    end
    idle(2);
    check("full_count", wr_log.size(), int'(SX * SY));
    check("full_last_addr", last_addr, int'(SX * SY) - 1);
    if (wr_log.size() > int'(SX)) check("full_line1_start", wr_log[SX], int'(SX));
    else check("full_line1_missing", wr_log.size(), int'(SX) + 1);
    fd0 = act_fd;
    vs_rise();
    check("full_frame_done", act_fd - fd0, 1);

    // clipping: wider and taller than the stored window
    vs_fall();
    start_test();
    for (int l = 0; l < int'(SY) + 2; l++) begin
      rand_bytes(2 * int'(SX) + 8, q);
      drive_line(q, 1'b0, 4);
    end
    idle(2);
    check("clip_count", wr_log.size(), int'(SX * SY));
    check("clip_max_addr", max_addr, int'(SX * SY) - 1);
    fd0 = act_fd;
    vs_rise();
    check("clip_frame_done", act_fd - fd0, 1);

    // odd-length line followed by a normal line
    vs_fall();
    start_test();
    rand_bytes(3, q);
    drive_line(q, 1'b0, 4);
    rand_bytes(8, q);
    drive_line(q, 1'b0, 4);
    check("odd_count", wr_log.size(), 5);
    if (wr_log.size() >= 2) begin
      check("odd_first", wr_log[0], 0);
      check("odd_next_line", wr_log[1], int'(SX));
    end
    vs_rise();

    // Vsync rising mid-line aborts the line
    vs_fall();
    start_test();
    rand_bytes(20, q);
    drive_line(q, 1'b1, 0);
    fd0 = act_fd;
    vs_rise();
    rand_bytes(12, q);
    drive_line(q, 1'b0, 2);
    idle(3);
    check("abort_frame_done", act_fd - fd0, 1);
    check("abort_count", wr_log.size(), 10);

    // asynchronous reset mid-line
    vs_fall();
    start_test();
    rand_bytes(20, q);
    drive_line(q, 1'b1, 0);
    fd0 = act_fd;
    @(negedge clk);
    rst = 1'b0;
    armed = 1'b0;
    in_frame = 1'b0;
    #1;
    check_outputs_zero("midline_reset");
    bus.Href = 1'b0;
    idle(2);
    rst = 1'b1;
    rand_bytes(20, q);
    drive_line(q, 1'b0, 4);
    vs_rise();
    check("reset_no_frame_done", act_fd - fd0, 0);
    check("reset_count", wr_log.size(), 10);
    vs_fall();
    rand_bytes(20, q);
    drive_line(q, 1'b0, 4);
    vs_rise();
    check("resume_count", wr_log.size(), 20);

    // random short frames with odd/even lengths and gaps
    for (int f = 0; f < 4; f++) begin
      vs_fall();
      for (int l = 0; l < int'($urandom_range(1, 5)); l++) begin
        rand_bytes(int'($urandom_range(1, 360)), q);
        drive_line(q, 1'b0, int'($urandom_range(1, 4)));
      end
      vs_rise();
    end

    idle(10);
    check("queue_drained", exp_q.size(), 0);
    check("frame_done_total", act_fd, exp_fd);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
